// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver FSM encoding and frame constants.
// Shared with downstream scan-code consumers (break/extended prefix decoding).
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam int          FRAME_BITS      = 11;
   localparam int          DATA_BITS       = 8;
   localparam logic        ODD_PARITY      = 1'b1;
   localparam logic [7:0]  BREAK_PREFIX    = 8'hF0;
   localparam logic [7:0]  EXTENDED_PREFIX = 8'hE0;

   // True when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return (^{data, par}) == ODD_PARITY;
   endfunction

   function automatic logic parity_bit(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// rtl/ps2_scan_rx_if.sv - PS/2 device lines and received scan-code outputs.
interface ps2_scan_rx_if;

   logic        kclk;
   logic        kdata;
   logic [15:0] keycode;
   logic        oflag;
   logic        err;

   modport master (
      output kclk,
      output kdata,
      input  keycode,
      input  oflag,
      input  err
   );

   modport slave (
      input  kclk,
      input  kdata,
      output keycode,
      output oflag,
      output err
   );

endinterface

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - kclk synchronizer, saturating glitch filter, fall strobe.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fall_q, fall_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   // Any sample matching the current filtered level restarts the run count.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      fall_d = filt_q & ~filt_d;
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver with 2-byte scan-code history.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic              clk,
   input  logic              rst,
   ps2_scan_rx_if.slave      bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [15:0]   keycode_q, keycode_d;
   logic          oflag_q, oflag_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          kd1_q, kd1_d;
   logic          kd2_q, kd2_d;
   logic          fall;
   logic          tmo_fire;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk  (clk),
      .rst  (rst),
      .raw  (bus.kclk),
      .fall (fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         keycode_q <= '0;
         oflag_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= '0;
         kd1_q     <= 1'b1;
         kd2_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         keycode_q <= keycode_d;
         oflag_q   <= oflag_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         kd1_q     <= kd1_d;
         kd2_q     <= kd2_d;
      end
   end

   assign tmo_fire = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

   // Timeout takes priority over a coincident fall event.
   always_comb begin
      kd1_d     = bus.kdata;
      kd2_d     = kd1_q;
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      keycode_d = keycode_q;
      oflag_d   = 1'b0;
      err_d     = 1'b0;
      tmo_d     = '0;
      if (state_q != ST_IDLE) begin
         tmo_d = tmo_q + 1'b1;
      end
      if (tmo_fire) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         tmo_d     = '0;
         err_d     = 1'b1;
      end else if (fall) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!kd2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d = {kd2_q, shift_q[7:1]};
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d   = ST_PARITY;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               parity_d = kd2_q;
               state_d  = ST_STOP;
            end
            ST_STOP: begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               if (kd2_q && odd_parity_ok(shift_q, parity_q)) begin
                  keycode_d = {keycode_q[7:0], shift_q};
                  oflag_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign bus.keycode = keycode_q;
   assign bus.oflag   = oflag_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - scoreboard bench for ps2_scan_rx at a 12.5 kHz kclk.
`timescale 1ns/1ps
module tb_ps2_scan_rx;
   import ps2_pkg::*;

   localparam int TMO = 1000;

   typedef struct {
      logic        is_err;
      logic        tmo;
      logic [15:0] kc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          last_fall_cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          n_oflag = 0;
   int          n_err = 0;
   int          n_exp_oflag = 0;
   int          n_exp_err = 0;
   logic [15:0] model_kc;
   exp_t        q[$];

   always #500 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_scan_rx_if bus();

   ps2_scan_rx #(
      .FILTER_LEN  (8),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.oflag || bus.err) begin
         if (bus.oflag) n_oflag++;
         if (bus.err) n_err++;
         chk("excl", 32'(bus.oflag & bus.err), 0);
         chk("no_pulse_in_rst", 32'(rst), 0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            chk("kind_err", 32'(bus.err), 32'(e.is_err));
            chk("keycode", 32'(bus.keycode), 32'(e.kc));
            if (e.tmo)
               chk("tmo_window", 32'((cyc - last_fall_cyc >= TMO) && (cyc - last_fall_cyc <= TMO + 20)), 1);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.kdata = bits[i];
         wait_cyc(20);
         bus.kclk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(40);
         bus.kclk = 1'b1;
         wait_cyc(20);
      end
   endtask

   task automatic push_exp(input logic is_err, input logic tmo);
      exp_t e;
      e.is_err = is_err;
      e.tmo    = tmo;
      e.kc     = model_kc;
      q.push_back(e);
      if (is_err) n_exp_err++;
      else n_exp_oflag++;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop);
      logic p;
      p = parity_bit(b) ^ bad_par;
      if (!bad_par && stop) begin
         model_kc = {model_kc[7:0], b};
         push_exp(1'b0, 1'b0);
      end else begin
         push_exp(1'b1, 1'b0);
      end
      send_bits({stop, p, b, 1'b0}, 11);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && q.size() != 0; i++) wait_cyc(1);
      chk(tag, 32'(q.size()), 0);
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      bus.kclk  = 1'b1;
      bus.kdata = 1'b1;
      model_kc  = '0;
      wait_cyc(5);
      chk("rst_keycode", 32'(bus.keycode), 0);
      chk("rst_oflag", 32'(bus.oflag), 0);
      chk("rst_err", 32'(bus.err), 0);
      rst = 1'b0;
      wait_cyc(10);

      bus.kclk = 1'b0;
      wait_cyc(3);
      bus.kclk = 1'b1;
      wait_cyc(50);
      chk("glitch_quiet", 32'(n_oflag + n_err), 0);

      send_byte(8'h1C, 1'b0, 1'b1);
      drain("drain_1c");
      chk("first_keycode", 32'(bus.keycode), 32'h001C);

      send_byte(BREAK_PREFIX, 1'b0, 1'b1);
      send_byte(8'h1C, 1'b0, 1'b1);
      drain("drain_make_break");
      chk("make_break_kc", 32'(bus.keycode), 32'hF01C);

      send_byte(8'h1C, 1'b1, 1'b1);
      send_byte(8'h32, 1'b0, 1'b1);
      drain("drain_parity");
      chk("after_parity_low", 32'(bus.keycode[7:0]), 32'h32);

      send_byte(8'h11, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0);
      send_bits(11'h001, 1);
      drain("drain_stop_start");

      push_exp(1'b1, 1'b1);
      send_bits(11'h014, 5);
      wait_cyc(TMO + 100);
      drain("drain_timeout");
      send_byte(8'h29, 1'b0, 1'b1);
      drain("drain_after_tmo");

      send_byte(BREAK_PREFIX, 1'b0, 1'b1);
      send_byte(BREAK_PREFIX, 1'b0, 1'b1);
      drain("drain_dup");
      chk("dup_keycode", 32'(bus.keycode), 32'hF0F0);

      send_bits(11'h02A, 6);
      rst = 1'b1;
      wait_cyc(2);
      chk("midrst_keycode", 32'(bus.keycode), 0);
      chk("midrst_oflag", 32'(bus.oflag), 0);
      chk("midrst_err", 32'(bus.err), 0);
      model_kc = '0;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(10);
      send_byte(8'h5A, 1'b0, 1'b1);
      drain("drain_5a");
      chk("final_keycode", 32'(bus.keycode), 32'h005A);

      wait_cyc(50);
      chk("oflag_count", 32'(n_oflag), 32'(n_exp_oflag));
      chk("err_count", 32'(n_err), 32'(n_exp_err));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical clk samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYC, default 200000: maximum clk cycles allowed between filtered falling edges inside one frame.
REQ-003 Port clk  input  1: system clock; all logic on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port kclk  input  1: raw PS/2 clock from the device, asynchronous to clk.
REQ-006 Port kdata  input  1: raw PS/2 data from the device, asynchronous to clk.
REQ-007 Port keycode  output  16: history of received bytes; [7:0] is the newest byte, [15:8] the previous byte.
REQ-008 Port oflag  output  1: one-cycle pulse marking a keycode update.
REQ-009 Port err  output  1: one-cycle pulse on a rejected frame (bad start, parity, stop or timeout).

Function
REQ-010 kclk and kdata SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The synchronized kclk SHALL feed a saturating counter filter: the filtered level changes only after FILTER_LEN consecutive samples at the opposite level.
REQ-012 A fall event SHALL be a 1-cycle strobe in the cycle the filtered clock goes 1->0; synchronized kdata is sampled in that same cycle.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on a fall event with data=0, go to DATA with bit count 0; with data=1, stay in IDLE and pulse err.
REQ-015 DATA: each fall event shifts data in LSB-first; after the 8th bit, go to PARITY.
REQ-016 PARITY: the fall event captures the parity bit and goes to STOP.
REQ-017 STOP: the fall event returns the FSM to IDLE.
REQ-018 A frame SHALL be valid only if stop=1 and the 8 data bits plus the parity bit have odd parity.
REQ-019 Valid frame: in the cycle after the stop fall event, keycode becomes {keycode[7:0], byte} and oflag=1 for exactly that cycle.
REQ-020 Invalid frame: keycode is unchanged, oflag stays 0, and err=1 for the cycle after the stop fall event.
REQ-021 A timeout counter SHALL clear on every fall event and increment in DATA, PARITY and STOP; reaching TIMEOUT_CYC forces IDLE, clears the bit count, and pulses err once. The counter is held at 0 in IDLE.
REQ-022 oflag and err SHALL never be asserted in the same cycle.
REQ-023 Back-to-back valid frames SHALL each produce exactly one oflag; no frames are dropped at the 10-16.7 kHz PS/2 rate.
REQ-024 A fall event in the same cycle the timeout fires SHALL be ignored; the timeout wins.
REQ-025 Consecutive identical bytes (e.g. 0xF0, 0xF0) SHALL each update keycode and pulse oflag; this block performs no de-duplication.

Reset
REQ-026 On rst=1, immediately: FSM=IDLE, keycode=16'h0000, oflag=0, err=0; bit count, shift register and timeout counter cleared; synchronizer flops and filtered clock set to 1 (bus-idle level).
REQ-027 A reset asserted mid-frame SHALL discard the partial frame with no oflag or err pulse; after release, the next start bit begins a fresh frame.

Structure
REQ-028 The FSM state encoding and the PS/2 frame constants (11 bits per frame, odd parity, break prefix 8'hF0, extended prefix 8'hE0) SHALL live in a shared ps2_pkg package, for reuse by the consumer logic.
REQ-029 The synchronizer plus glitch filter SHALL be one sub-module, ps2_clk_filter, instantiated once for kclk; kdata uses only the 2-flop synchronizer.

Verification
REQ-030 Clean frame, byte 8'h1C (parity 0) at a 12.5 kHz kclk -> exactly one oflag; keycode=16'h001C.
REQ-031 Make/break sequence 8'h1C, 8'hF0, 8'h1C -> three oflag pulses; final keycode=16'hF01C; err never asserted.
REQ-032 Byte 8'h1C sent with parity=1 -> err pulses once, no oflag, keycode unchanged; a following valid 8'h32 is received (keycode low byte = 8'h32).
REQ-033 kclk stopped after 4 data bits, TIMEOUT_CYC=1000 -> err pulses 1000 cycles after the last fall event, FSM returns to IDLE, and the next full frame is accepted.
REQ-034 Glitch of 3 clk cycles low on kclk while idle, FILTER_LEN=8 -> no fall event, no err, no oflag.
REQ-035 rst asserted after the 5th data bit, then released, then a valid 8'h5A frame -> no pulse during reset; keycode=16'h005A with a single oflag.
